// File: rtl/keypoint_fifo_buffer.sv
// Circular FIFO of keypoint records (orientation, position, score).
// The head record is read combinationally from storage. When the buffer is
// full, a lone push is either dropped or evicts the oldest record, depending
// on OVERWRITE. Every lost record is counted in a saturating 16-bit counter.
module keypoint_fifo_buffer #(
  parameter int DEPTH     = 64,
  parameter int COOR_W    = 10,
  parameter int SCORE_W   = 8,
  parameter int TRIG_W    = 12,
  parameter int OVERWRITE = 0,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [TRIG_W-1:0]  i_sin,
  input  logic [TRIG_W-1:0]  i_cos,
  input  logic [COOR_W-1:0]  i_coor_x,
  input  logic [COOR_W-1:0]  i_coor_y,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [TRIG_W-1:0]  o_sin,
  output logic [TRIG_W-1:0]  o_cos,
  output logic [COOR_W-1:0]  o_coor_x,
  output logic [COOR_W-1:0]  o_coor_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic [15:0]        o_drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [TRIG_W-1:0]  sin;
    logic [TRIG_W-1:0]  cos;
    logic [COOR_W-1:0]  x;
    logic [COOR_W-1:0]  y;
    logic [SCORE_W-1:0] score;
  } kp_t;

  kp_t              mem [DEPTH];
  kp_t              head;
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      drop_cnt;

  logic full, empty;
  logic pop_acc, push_wr, evict, drop, inc, dec;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Decide which requests are accepted this cycle.
  // A push is written unless the buffer is full, no pop frees a slot, and the
  // policy is to drop. With OVERWRITE, a lone push while full evicts the head.
  always_comb begin
    pop_acc = i_pop & ~empty;
    push_wr = i_push & (~full | pop_acc | (OVERWRITE != 0));
    evict   = i_push & full & ~i_pop & (OVERWRITE != 0);
    drop    = i_push & full & ~i_pop;
    inc     = push_wr & ~pop_acc & ~full;
    dec     = pop_acc & ~push_wr;
  end

  // Pointer, occupancy and drop-counter state. Clear takes priority over traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (i_clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_wr)
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
      if (pop_acc | evict)
        rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
      if (inc)
        count <= count + CNT_W'(1);
      else if (dec)
        count <= count - CNT_W'(1);
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Record storage. It is not reset because the pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (!i_clear && push_wr)
      mem[wptr] <= '{sin: i_sin, cos: i_cos, x: i_coor_x, y: i_coor_y, score: i_score};
  end

  // Present the head record, forced to zero while the buffer is empty.
  always_comb begin
    head = '0;
    if (!empty)
      head = mem[rptr];
  end

  assign o_valid    = ~empty;
  assign o_sin      = head.sin;
  assign o_cos      = head.cos;
  assign o_coor_x   = head.x;
  assign o_coor_y   = head.y;
  assign o_score    = head.score;
  assign o_count    = count;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_keypoint_fifo_buffer.sv
// Directed bench for keypoint_fifo_buffer with DEPTH=4. It runs a drop-policy
// instance and an overwrite-policy instance side by side on the same stimulus.
// Each record uses x as its key: y=x+16, score=x+32, sin=x+100, cos=x+200.
module tb_keypoint_fifo_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [11:0] sin_i = '0, cos_i = '0;
  logic [9:0]  x_i = '0, y_i = '0;
  logic [7:0]  score_i = '0;

  logic             v0, v1, f0, f1, e0, e1;
  logic [11:0]      sin0, sin1, cos0, cos1;
  logic [9:0]       x0, x1, y0, y1;
  logic [7:0]       sc0, sc1;
  logic [CNT_W-1:0] c0, c1;
  logic [15:0]      d0, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypoint_fifo_buffer #(.DEPTH(DEPTH), .OVERWRITE(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push),
    .i_sin(sin_i), .i_cos(cos_i), .i_coor_x(x_i), .i_coor_y(y_i), .i_score(score_i),
    .i_pop(pop), .o_valid(v0), .o_sin(sin0), .o_cos(cos0), .o_coor_x(x0),
    .o_coor_y(y0), .o_score(sc0), .o_count(c0), .o_full(f0), .o_empty(e0),
    .o_drop_cnt(d0));

  keypoint_fifo_buffer #(.DEPTH(DEPTH), .OVERWRITE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push),
    .i_sin(sin_i), .i_cos(cos_i), .i_coor_x(x_i), .i_coor_y(y_i), .i_score(score_i),
    .i_pop(pop), .o_valid(v1), .o_sin(sin1), .o_cos(cos1), .o_coor_x(x1),
    .o_coor_y(y1), .o_score(sc1), .o_count(c1), .o_full(f1), .o_empty(e1),
    .o_drop_cnt(d1));

  // One cycle of stimulus, plus the state expected after the clock edge.
  // hx0/hx1 are the head x of each instance (0 means empty).
  typedef struct {
    logic clr, psh, pp;
    int   x;
    int   cnt;
    int   hx0, dr0, hx1, dr1;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic clr, psh, pp, input int x, cnt, hx0, dr0, hx1, dr1);
    vec_t v;
    v.clr = clr; v.psh = psh; v.pp = pp; v.x = x; v.cnt = cnt;
    v.hx0 = hx0; v.dr0 = dr0; v.hx1 = hx1; v.dr1 = dr1;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, psh, pp, input int x);
    clear   = clr;
    push    = psh;
    pop     = pp;
    x_i     = 10'(x);
    y_i     = 10'(x + 16);
    score_i = 8'(x + 32);
    sin_i   = 12'(x + 100);
    cos_i   = 12'(x + 200);
  endtask

  // Compare both instances against an expected count and head key.
  task automatic check_state(input string tag, input int cnt, hx0, dr0, hx1, dr1);
    check({tag, " count0"}, int'(c0), cnt);
    check({tag, " count1"}, int'(c1), cnt);
    check({tag, " full0"},  int'(f0), int'(cnt == DEPTH));
    check({tag, " empty1"}, int'(e1), int'(cnt == 0));
    check({tag, " valid0"}, int'(v0), int'(cnt != 0));
    check({tag, " x0"},     int'(x0), hx0);
    check({tag, " y0"},     int'(y0),   (hx0 == 0) ? 0 : hx0 + 16);
    check({tag, " score0"}, int'(sc0),  (hx0 == 0) ? 0 : hx0 + 32);
    check({tag, " sin0"},   int'(sin0), (hx0 == 0) ? 0 : hx0 + 100);
    check({tag, " cos0"},   int'(cos0), (hx0 == 0) ? 0 : hx0 + 200);
    check({tag, " x1"},     int'(x1), hx1);
    check({tag, " y1"},     int'(y1),   (hx1 == 0) ? 0 : hx1 + 16);
    check({tag, " drop0"},  int'(d0), dr0);
    check({tag, " drop1"},  int'(d1), dr1);
  endtask

  initial begin
    // Fill to full; a lone push of 5 is dropped by dut0 and evicts 1 in dut1.
    // Then drain, and pop once more while empty.
    add(0,1,0, 1, 1, 1,0, 1,0);
    add(0,1,0, 2, 2, 1,0, 1,0);
    add(0,1,0, 3, 3, 1,0, 1,0);
    add(0,1,0, 4, 4, 1,0, 1,0);
    add(0,1,0, 5, 4, 1,1, 2,1);
    add(0,0,1, 0, 3, 2,1, 3,1);
    add(0,0,1, 0, 2, 3,1, 4,1);
    add(0,0,1, 0, 1, 4,1, 5,1);
    add(0,0,1, 0, 0, 0,1, 0,1);
    add(0,0,1, 0, 0, 0,1, 0,1);
    // Clear the drop counters. Push and pop together while empty, then fill.
    // Push and pop together while full: the head advances and nothing is dropped.
    add(1,0,0, 0, 0, 0,0, 0,0);
    add(0,1,1, 6, 1, 6,0, 6,0);
    add(0,1,0, 7, 2, 6,0, 6,0);
    add(0,1,0, 8, 3, 6,0, 6,0);
    add(0,1,0, 9, 4, 6,0, 6,0);
    add(0,1,1,10, 4, 7,0, 7,0);
    // Write-pointer wrap: push 3, pop 2, push 3, then drain in order.
    add(1,0,0, 0, 0, 0,0, 0,0);
    add(0,1,0, 1, 1, 1,0, 1,0);
    add(0,1,0, 2, 2, 1,0, 1,0);
    add(0,1,0, 3, 3, 1,0, 1,0);
    add(0,0,1, 0, 2, 2,0, 2,0);
    add(0,0,1, 0, 1, 3,0, 3,0);
    add(0,1,0, 4, 2, 3,0, 3,0);
    add(0,1,0, 5, 3, 3,0, 3,0);
    add(0,1,0, 6, 4, 3,0, 3,0);
    add(0,0,1, 0, 3, 4,0, 4,0);
    add(0,0,1, 0, 2, 5,0, 5,0);
    add(0,0,1, 0, 1, 6,0, 6,0);
    add(0,0,1, 0, 0, 0,0, 0,0);
    // Push and pop together at mid occupancy leave the count unchanged.
    add(0,1,0,20, 1,20,0,20,0);
    add(0,1,0,21, 2,20,0,20,0);
    add(0,1,1,22, 2,21,0,21,0);
    add(0,0,1, 0, 1,22,0,22,0);
    add(0,0,1, 0, 0, 0,0, 0,0);
    // Fill, drop one, then clear together with push: everything returns to zero.
    add(0,1,0, 7, 1, 7,0, 7,0);
    add(0,1,0, 8, 2, 7,0, 7,0);
    add(0,1,0, 9, 3, 7,0, 7,0);
    add(0,1,0,10, 4, 7,0, 7,0);
    add(0,1,0,11, 4, 7,1, 8,1);
    add(1,1,0,12, 0, 0,0, 0,0);

    // Reset state, checked while reset is held.
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0,0, 0,0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].psh, vt[i].pp, vt[i].x);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].hx0, vt[i].dr0, vt[i].hx1, vt[i].dr1);
    end

    // Asynchronous reset between edges with 3 records held.
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 0, k);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0);
    check_state("pre_rst", 3, 1,0, 1,0);
    #2 rst_n = 1'b0;
    #1 check_state("async_rst", 0, 0,0, 0,0);
    @(negedge clk);
    rst_n = 1'b1;
    // A pop right after release must be ignored.
    drive(0, 0, 1, 0);
    @(posedge clk); #1;
    check_state("pop_after_rst", 0, 0,0, 0,0);
    // The first push after release appears one cycle later.
    drive(0, 1, 0, 9);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    check_state("push_after_rst", 1, 9,0, 9,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypoint_fifo_buffer.md
KEYPOINT_FIFO_BUFFER -- requirements
Module: keypoint_fifo_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of keypoint record slots (legal range 2..1024).
REQ-002 The block SHALL have parameter COOR_W, default 10, meaning the x/y coordinate field width.
REQ-003 The block SHALL have parameter SCORE_W, default 8, meaning the FAST score field width.
REQ-004 The block SHALL have parameter TRIG_W, default 12, meaning the sin/cos field width.
REQ-005 The block SHALL have parameter OVERWRITE, default 0, meaning the full policy: 0 drops the new record, 1 evicts the oldest record.
REQ-006 The block SHALL derive CNT_W = clog2(DEPTH+1) internally; it SHALL NOT be user-set.
REQ-007 The block SHALL have port i_clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-008 The block SHALL have port i_rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-009 The block SHALL have port i_clear, input, 1 bit, the synchronous flush.
REQ-010 The block SHALL have port i_push, input, 1 bit, the write request for the record on i_sin/i_cos/i_coor_x/i_coor_y/i_score.
REQ-011 The block SHALL have ports i_sin and i_cos, input, TRIG_W bits each, the orientation of the incoming record.
REQ-012 The block SHALL have ports i_coor_x and i_coor_y, input, COOR_W bits each, the position of the incoming record.
REQ-013 The block SHALL have port i_score, input, SCORE_W bits, the score of the incoming record.
REQ-014 The block SHALL have port i_pop, input, 1 bit, which consumes the head record.
REQ-015 The block SHALL have port o_valid, output, 1 bit, asserted when the head record is valid (count nonzero).
REQ-016 The block SHALL have ports o_sin, o_cos, o_coor_x, o_coor_y and o_score, output, with the same widths as their inputs, carrying the head (oldest) record.
REQ-017 The block SHALL have port o_count, output, CNT_W bits, the occupancy.
REQ-018 The block SHALL have ports o_full and o_empty, output, 1 bit each, meaning count==DEPTH and count==0 respectively.
REQ-019 The block SHALL have port o_drop_cnt, output, 16 bits, counting lost records and saturating at 16'hFFFF.

Function
REQ-020 Storage SHALL be a circular buffer with write pointer, read pointer and count registers; pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of 2.
REQ-021 A push SHALL be accepted when !o_full; the record is written at wptr, wptr advances, and count increments.
REQ-022 A pop SHALL be accepted when o_valid; rptr advances and count decrements; a pop while empty SHALL be ignored with no state change.
REQ-023 Outputs SHALL show the record at rptr, read combinationally from registers; push-to-output latency is 1 cycle when the buffer was empty.
REQ-024 While o_empty, o_sin, o_cos, o_coor_x, o_coor_y and o_score SHALL be driven to 0.
REQ-025 Push+pop in the same cycle with count between 1 and DEPTH-1: both SHALL be accepted and count SHALL be unchanged.
REQ-026 Push+pop in the same cycle while empty: the push SHALL be accepted, the pop ignored, and count becomes 1 (no fall-through).
REQ-027 Push+pop in the same cycle while full: both SHALL be accepted, count stays DEPTH, and no drop is recorded, regardless of OVERWRITE.
REQ-028 Push alone while full with OVERWRITE=0: the record SHALL be discarded, storage and pointers unchanged, and o_drop_cnt incremented.
REQ-029 Push alone while full with OVERWRITE=1: the record SHALL be written at wptr, both pointers advance, count stays DEPTH, and o_drop_cnt is incremented.
REQ-030 i_clear SHALL have priority over push and pop; next cycle pointers, count and o_drop_cnt SHALL be 0; stored data need not be cleared.
REQ-031 o_full, o_empty and o_count SHALL be derived from the count register only, with no extra latency.

Reset
REQ-032 On i_rst_n low, pointers, count and o_drop_cnt SHALL reset to 0 asynchronously; o_valid=0, o_empty=1, o_full=0, and all data outputs = 0.
REQ-033 Assertion of reset mid-operation SHALL discard all contents; the first push after release SHALL appear at the output 1 cycle later.

Verification (DEPTH=4, default widths)
REQ-034 Push x=1..4 in 4 consecutive cycles -> o_full=1, o_count=4, o_coor_x=1; pop 4 times -> o_coor_x sequence 1,2,3,4, then o_empty=1 and outputs 0.
REQ-035 With the buffer full (x=1..4) and OVERWRITE=0, push x=5 -> o_count=4, head x=1, o_drop_cnt=1; pop all -> 1,2,3,4.
REQ-036 Same as REQ-035 with OVERWRITE=1 -> head x=2, o_drop_cnt=1; pop all -> 2,3,4,5.
REQ-037 Push and pop together while empty -> o_count=1, head = pushed record; push and pop together while full -> o_count=4, head advances by one, o_drop_cnt=0.
REQ-038 Push 3 records, pop 2, then push 3 more (wptr wraps) -> o_count=4 and FIFO order is preserved; i_clear together with i_push -> o_count=0 and o_drop_cnt=0 next cycle.
REQ-039 Assert i_rst_n low asynchronously between clock edges while count=3 -> o_count=0 and o_valid=0 immediately; pop after release is ignored.
